// File: rtl/data_memory_unit.sv
// data_memory_unit: MEM-stage byte/half/word data memory with misalignment flag and post-reset clear
// Ports:
//   clk, rst       rising-edge clock, synchronous active-high reset
//   MemRead        load request this cycle
//   MemWrite       store request this cycle
//   mem_size       00 byte, 01 half, 10 word, 11 treated as word
//   mem_unsigned   1 = zero-extend loads, 0 = sign-extend
//   address        byte address; bits above the array size are ignored (wrap)
//   write_data     store data, low bits used for byte/half stores
//   read_data      combinational extended load data, 0 when idle, busy or misaligned
//   misaligned     registered one-cycle pulse for the previous cycle's faulting access
//   init_busy      high while the post-reset clear sweeps the array
module data_memory_unit #(
    parameter int DEPTH_LOG2 = 8
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        MemRead,
    input  logic        MemWrite,
    input  logic [1:0]  mem_size,
    input  logic        mem_unsigned,
    input  logic [31:0] address,
    input  logic [31:0] write_data,
    output logic [31:0] read_data,
    output logic        misaligned,
    output logic        init_busy
);
    localparam int DEPTH = 1 << DEPTH_LOG2;
    typedef enum logic {CLEAR, READY} state_t;
    state_t state, next_state;
    logic [DEPTH_LOG2-1:0] clr_idx, idx;
    logic [31:0] mem [DEPTH];
    logic [31:0] word, lane_data, loaded;
    logic [15:0] half;
    logic [7:0]  bytev;
    logic [3:0]  byte_en;
    logic        is_byte, is_half, mis_cond, active, unused_addr;

    assign idx         = address[DEPTH_LOG2+1:2];
    assign unused_addr = ^address[31:DEPTH_LOG2+2];
    assign is_byte     = mem_size == 2'b00;
    assign is_half     = mem_size == 2'b01;
    assign mis_cond    = is_byte ? 1'b0 : is_half ? address[0] : |address[1:0];
    // rst is folded in so the reset cycle itself already reports busy
    assign init_busy   = rst | (state == CLEAR);
    assign active      = ~init_busy & ~mis_cond;

    // Replicating the store data lets every lane pick its byte without a shifter
    assign byte_en   = is_byte ? 4'b0001 << address[1:0] : is_half ? (address[1] ? 4'b1100 : 4'b0011) : 4'b1111;
    assign lane_data = is_byte ? {4{write_data[7:0]}} : is_half ? {2{write_data[15:0]}} : write_data;

    assign word      = mem[idx];
    assign half      = address[1] ? word[31:16] : word[15:0];
    assign bytev     = address[0] ? half[15:8] : half[7:0];
    assign loaded    = is_byte ? {{24{~mem_unsigned & bytev[7]}}, bytev}
                     : is_half ? {{16{~mem_unsigned & half[15]}}, half} : word;
    assign read_data = (MemRead & active) ? loaded : '0;

    always_comb begin
        next_state = state;
        if (state == CLEAR && &clr_idx) next_state = READY;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= CLEAR;
            clr_idx    <= '0;
            misaligned <= 1'b0;
        end else begin
            state      <= next_state;
            clr_idx    <= (state == CLEAR) ? clr_idx + 1'b1 : '0;
            misaligned <= ~init_busy & (MemRead | MemWrite) & mis_cond;
        end
    end

    // Array has no reset; the CLEAR sweep zeroes it one word per cycle
    always_ff @(posedge clk) begin
        if (state == CLEAR) mem[clr_idx] <= '0;
        else if (MemWrite & active)
            for (int i = 0; i < 4; i++)
                if (byte_en[i]) mem[idx][8*i +: 8] <= lane_data[8*i +: 8];
    end
endmodule

// File: tb/tb_data_memory_unit.sv
// tb_data_memory_unit: scoreboard bench for data_memory_unit with a 16-word array
module tb_data_memory_unit;
    localparam logic [1:0] B = 2'b00, H = 2'b01, W = 2'b10, R = 2'b11;
    logic        clk = 0, rst = 0, MemRead = 0, MemWrite = 0, mem_unsigned = 0;
    logic [1:0]  mem_size = W;
    logic [31:0] address = 0, write_data = 0, read_data;
    logic        misaligned, init_busy, obs_mis;
    logic [31:0] exp_q[$], obs_q[$];
    int          checks = 0, errors = 0;

    always #5 clk = ~clk;

    data_memory_unit #(.DEPTH_LOG2(4)) dut (
        .clk(clk), .rst(rst), .MemRead(MemRead), .MemWrite(MemWrite),
        .mem_size(mem_size), .mem_unsigned(mem_unsigned), .address(address),
        .write_data(write_data), .read_data(read_data), .misaligned(misaligned),
        .init_busy(init_busy)
    );

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    // One access cycle: read_data sampled mid-cycle, misaligned sampled just after the edge
    task automatic drive(input logic rd, input logic wr, input logic [1:0] sz, input logic uns,
                         input logic [31:0] a, input logic [31:0] wd);
        MemRead = rd; MemWrite = wr; mem_size = sz; mem_unsigned = uns; address = a; write_data = wd;
        @(negedge clk);
        if (rd) obs_q.push_back(read_data);
        @(posedge clk);
        #1;
        obs_mis = misaligned;
        MemRead = 0; MemWrite = 0;
    endtask

    task automatic test_reset;
        int cnt = 0;
        logic [31:0] e, o;
        rst = 1;
        #1;
        checks++;
        if (init_busy !== 1'b1) begin errors++; $display("FAIL reset_busy_in_rst: got %b expected 1", init_busy); end
        @(posedge clk); #1; rst = 0;
        checks++;
        if (misaligned !== 1'b0) begin errors++; $display("FAIL reset_misaligned: got %b expected 0", misaligned); end
        MemRead = 1; mem_size = W; address = 0; #1;
        checks++;
        if (read_data !== 32'h0) begin errors++; $display("FAIL reset_read_busy: got %h expected 0", read_data); end
        MemRead = 0;
        while (init_busy === 1'b1 && cnt < 100) begin @(posedge clk); #1; cnt++; end
        checks++;
        if (cnt !== 16) begin errors++; $display("FAIL reset_busy_cycles: got %0d expected 16", cnt); end
        for (int i = 0; i < 16; i++) begin exp_q.push_back(32'h0); drive(1, 0, W, 0, 32'(i * 4), 0); end
        for (int n = 0; exp_q.size() > 0; n++) begin
            e = exp_q.pop_front(); o = (obs_q.size() > 0) ? obs_q.pop_front() : 'x;
            checks++;
            if (o !== e) begin errors++; $display("FAIL reset_clear_word %0d: got %h expected %h", n, o, e); end
        end
    endtask

    task automatic test_byte_half;
        logic [31:0] e, o;
        drive(0, 1, W, 0, 32'h10, 32'h0);
        drive(0, 1, B, 0, 32'h12, 32'h000000AB);
        exp_q.push_back(32'h00AB0000); drive(1, 0, W, 0, 32'h10, 0);
        exp_q.push_back(32'hFFFFFFAB); drive(1, 0, B, 0, 32'h12, 0);
        exp_q.push_back(32'h000000AB); drive(1, 0, B, 1, 32'h12, 0);
        exp_q.push_back(32'h000000AB); drive(1, 0, H, 0, 32'h12, 0);
        drive(0, 1, H, 0, 32'h10, 32'hFFFF8001);
        exp_q.push_back(32'hFFFF8001); drive(1, 0, H, 0, 32'h10, 0);
        exp_q.push_back(32'h00008001); drive(1, 0, H, 1, 32'h10, 0);
        exp_q.push_back(32'h00AB8001); drive(1, 0, W, 0, 32'h10, 0);
        for (int n = 0; exp_q.size() > 0; n++) begin
            e = exp_q.pop_front(); o = (obs_q.size() > 0) ? obs_q.pop_front() : 'x;
            checks++;
            if (o !== e) begin errors++; $display("FAIL byte_half load %0d: got %h expected %h", n, o, e); end
        end
    endtask

    task automatic test_misaligned;
        logic [31:0] e, o;
        drive(0, 1, W, 0, 32'h20, 32'h12345678);
        drive(0, 1, W, 0, 32'h21, 32'hDEADBEEF);
        checks++;
        if (obs_mis !== 1'b1) begin errors++; $display("FAIL mis_store_pulse: got %b expected 1", obs_mis); end
        drive(0, 0, W, 0, 32'h0, 0);
        checks++;
        if (obs_mis !== 1'b0) begin errors++; $display("FAIL mis_pulse_end: got %b expected 0", obs_mis); end
        exp_q.push_back(32'h12345678); drive(1, 0, W, 0, 32'h20, 0);
        exp_q.push_back(32'h0); drive(1, 0, H, 0, 32'h23, 0);
        checks++;
        if (obs_mis !== 1'b1) begin errors++; $display("FAIL mis_half_load: got %b expected 1", obs_mis); end
        exp_q.push_back(32'h00000012); drive(1, 0, B, 0, 32'h23, 0);
        checks++;
        if (obs_mis !== 1'b0) begin errors++; $display("FAIL mis_byte_never: got %b expected 0", obs_mis); end
        exp_q.push_back(32'h0); drive(1, 0, W, 0, 32'h22, 0);
        checks++;
        if (obs_mis !== 1'b1) begin errors++; $display("FAIL mis_word_load: got %b expected 1", obs_mis); end
        drive(0, 1, R, 0, 32'h24, 32'hA5A5A5A5);
        exp_q.push_back(32'hA5A5A5A5); drive(1, 0, W, 0, 32'h24, 0);
        exp_q.push_back(32'h0); drive(1, 0, R, 0, 32'h26, 0);
        checks++;
        if (obs_mis !== 1'b1) begin errors++; $display("FAIL mis_reserved: got %b expected 1", obs_mis); end
        for (int n = 0; exp_q.size() > 0; n++) begin
            e = exp_q.pop_front(); o = (obs_q.size() > 0) ? obs_q.pop_front() : 'x;
            checks++;
            if (o !== e) begin errors++; $display("FAIL misaligned load %0d: got %h expected %h", n, o, e); end
        end
    endtask

    task automatic test_back_to_back;
        logic [31:0] e, o;
        drive(0, 1, W, 0, 32'h30, 32'h11111111);
        exp_q.push_back(32'h11111111); drive(1, 1, W, 0, 32'h30, 32'h22222222);
        exp_q.push_back(32'h22222222); drive(1, 0, W, 0, 32'h30, 0);
        for (int n = 0; exp_q.size() > 0; n++) begin
            e = exp_q.pop_front(); o = (obs_q.size() > 0) ? obs_q.pop_front() : 'x;
            checks++;
            if (o !== e) begin errors++; $display("FAIL read_during_write %0d: got %h expected %h", n, o, e); end
        end
    endtask

    task automatic test_wrap;
        logic [31:0] e, o;
        drive(0, 1, W, 0, 32'h40, 32'h5A5A5A5A);
        exp_q.push_back(32'h5A5A5A5A); drive(1, 0, W, 0, 32'h00, 0);
        exp_q.push_back(32'h5A5A5A5A); drive(1, 0, W, 0, 32'hFFFFFF80, 0);
        for (int n = 0; exp_q.size() > 0; n++) begin
            e = exp_q.pop_front(); o = (obs_q.size() > 0) ? obs_q.pop_front() : 'x;
            checks++;
            if (o !== e) begin errors++; $display("FAIL wrap %0d: got %h expected %h", n, o, e); end
        end
    endtask

    task automatic test_reset_mid_clear;
        int cnt = 0;
        logic [31:0] e, o;
        rst = 1; @(posedge clk); #1; rst = 0;
        repeat (7) drive(0, 1, W, 0, 32'h04, 32'h77777777);
        rst = 1; @(posedge clk); #1; rst = 0;
        // Stores to word 0 and misaligned loads keep arriving throughout the clear
        while (init_busy === 1'b1 && cnt < 100) begin
            exp_q.push_back(32'h0);
            if (cnt % 2 == 0) drive(1, 1, W, 0, 32'h00, 32'hCAFEF00D);
            else drive(1, 0, W, 0, 32'h01, 0);
            checks++;
            if (obs_mis !== 1'b0) begin errors++; $display("FAIL clear_no_fault cycle %0d: got %b expected 0", cnt, obs_mis); end
            cnt++;
        end
        checks++;
        if (cnt !== 16) begin errors++; $display("FAIL restart_busy_cycles: got %0d expected 16", cnt); end
        exp_q.push_back(32'h0); drive(1, 0, W, 0, 32'h00, 0);
        exp_q.push_back(32'h0); drive(1, 0, W, 0, 32'h04, 0);
        for (int n = 0; exp_q.size() > 0; n++) begin
            e = exp_q.pop_front(); o = (obs_q.size() > 0) ? obs_q.pop_front() : 'x;
            checks++;
            if (o !== e) begin errors++; $display("FAIL mid_clear read %0d: got %h expected %h", n, o, e); end
        end
    endtask

    initial begin
        @(posedge clk); #1;
        test_reset();
        test_byte_half();
        test_misaligned();
        test_back_to_back();
        test_wrap();
        test_reset_mid_clear();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
